dmem_port_controller: RTL and testbench

- Two-requester front end for the 32-entry word-addressed data memory: arbitrates between port 0 (core load/store unit) and port 1 (debug/loader), sequences every access, returns responses.
- Always drives the memory as full words. Byte/halfword lane selection and sign/zero extension are done here.
- Sub-word stores are read-modify-write, so neighbouring bytes are preserved.
- Sits between requesters and data_memory; memory writes land on negedge, reads are combinational.

---
 rtl/dmem_port_controller.sv | 184 ++++++++++++++++++
 tb/tb_dmem_port_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_controller.sv
// Two-port front end for the word-addressed data memory: round-robin arbitration,
// alignment checking, lane select/extension and read-modify-write for sub-word stores.
module dmem_port_controller #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [3:0]              req_size,
  input  logic [1:0]              req_unsigned,
  input  logic [2*DATA_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [1:0]              mem_maskmode,
  output logic                    mem_sext,
  output logic [DATA_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH-1:0]   mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e          state_q;
  logic            last_grant_q;
  logic            port_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [1:0]      off_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic            mem_read_q;
  logic            mem_write_q;
  logic [1:0]      rsp_valid_q;
  logic            rsp_err_q;
  logic [31:0]     rsp_rdata_q;

  logic            grant_d;
  logic [1:0]      g_size;
  logic [31:0]     g_addr;
  logic [31:0]     g_wdata;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                        input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00:   r[{off, 3'b000} +: 8]     = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    grant_d = 1'b0;
    case (req_valid)
      2'b10:   grant_d = 1'b1;
      2'b11:   grant_d = ~last_grant_q;
      default: grant_d = 1'b0;
    endcase
    req_ready = '0;
    if (state_q == IDLE && req_valid != 2'b00) req_ready[grant_d] = 1'b1;
    g_size  = req_size[{grant_d, 1'b0} +: 2];
    g_addr  = req_addr[{grant_d, 5'b00000} +: 32];
    g_wdata = req_wdata[{grant_d, 5'b00000} +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((req_valid & req_ready) != 2'b00) begin
            last_grant_q <= grant_d;
            port_q       <= grant_d;
            we_q         <= req_we[grant_d];
            size_q       <= g_size;
            uns_q        <= req_unsigned[grant_d];
            off_q        <= g_addr[1:0];
            wdata_q      <= g_wdata;
            mem_addr_q   <= {g_addr[31:2], 2'b00};
            if (misaligned(g_size, g_addr[1:0])) begin
              rsp_valid_q[grant_d] <= 1'b1;
              rsp_err_q            <= 1'b1;
              rsp_rdata_q          <= '0;
              state_q              <= RESP;
            end else if (req_we[grant_d] && g_size == 2'b10) begin
              mem_wdata_q <= g_wdata;
              mem_write_q <= 1'b1;
              state_q     <= WRITE;
            end else begin
              // Loads and sub-word stores both start by fetching the full word.
              mem_read_q <= 1'b1;
              state_q    <= READ;
            end
          end
        end
        READ: begin
          mem_read_q <= 1'b0;
          if (we_q) begin
            mem_wdata_q <= merge(mem_read_data, size_q, off_q, wdata_q);
            mem_write_q <= 1'b1;
            state_q     <= WRITE;
          end else begin
            rsp_rdata_q         <= extract(mem_read_data, size_q, off_q, uns_q);
            rsp_err_q           <= 1'b0;
            rsp_valid_q[port_q] <= 1'b1;
            state_q             <= RESP;
          end
        end
        WRITE: begin
          mem_write_q         <= 1'b0;
          rsp_rdata_q         <= '0;
          rsp_err_q           <= 1'b0;
          rsp_valid_q[port_q] <= 1'b1;
          state_q             <= RESP;
        end
        RESP: begin
          rsp_valid_q <= '0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_maskmode   = 2'b10;
  assign mem_sext       = 1'b0;
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_controller.sv
// Scoreboard bench for dmem_port_controller with a negedge-write, combinational-read memory model.
module tb_dmem_port_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [3:0]  req_size = '0;
  logic [1:0]  req_unsigned = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write, mem_sext;
  logic [1:0]  mem_maskmode;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [32];

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          rdc = 0;
  int          wrc = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  logic        model_lg = 1'b1;

  dmem_port_controller #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_maskmode(mem_maskmode),
    .mem_sext(mem_sext), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (mem_write) mem[mem_address[6:2]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[6:2]];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  // Monitor: counts memory activity per transaction and checks each response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rdc = 0;
      wrc = 0;
    end else begin
      chk("rw_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      if (mem_read) rdc++;
      if (mem_write) begin
        wrc++;
        last_wa = mem_address;
        last_wd = mem_write_data;
      end
      if (rsp_valid != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", {30'b0, rsp_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_valid", {30'b0, rsp_valid}, e.port ? 32'd2 : 32'd1);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("latency", cyc - e.acc, e.lat);
          chk("n_reads", rdc, e.nrd);
          chk("n_writes", wrc, e.nwr);
        end
        rdc = 0;
        wrc = 0;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      chk("rsp_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic eerr,
                        input logic [31:0] erd, input int elat, input int enrd, input int enwr);
    bit got = 0;
    @(negedge clk);
    req_we[p] = we;
    req_size[2*p +: 2] = sz;
    req_unsigned[p] = uns;
    req_addr[32*p +: 32] = addr;
    req_wdata[32*p +: 32] = wd;
    req_valid[p] = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (req_ready[p]) begin
        got = 1;
        q.push_back('{port: p[0], err: eerr, rdata: erd, lat: elat, acc: cyc, nrd: enrd, nwr: enwr});
        model_lg = p[0];
        @(posedge clk);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    req_valid[p] = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    drain();
  endtask

  // Both ports hold word loads; grants must alternate starting from the port not last granted.
  task automatic rr(input int n, input logic [31:0] a0, input logic [31:0] d0,
                    input logic [31:0] a1, input logic [31:0] d1);
    logic nxt;
    int   grants = 0;
    bit   done = 0;
    @(negedge clk);
    req_we = 2'b00;
    req_size = 4'b1010;
    req_addr = {a1, a0};
    req_valid = 2'b11;
    nxt = ~model_lg;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("rr_ready", {30'b0, req_ready}, nxt ? 32'd2 : 32'd1);
        chk("rr_outstanding", q.size(), 0);
        q.push_back('{port: nxt, err: 1'b0, rdata: nxt ? d1 : d0, lat: 2, acc: cyc, nrd: 1, nwr: 0});
        model_lg = nxt;
        nxt = ~nxt;
        grants++;
      end
      if (grants == n) begin
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 2'b00;
    chk("rr_grants", grants, n);
    drain();
  endtask

  initial begin
    #1;
    chk("rst_ready", {30'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    chk("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_maskmode", {30'b0, mem_maskmode}, 32'd2);
    chk("rst_address", mem_address, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    #16 rst_n = 1'b1;

    do_req(1, 1, 2'b10, 0, 32'h10, 32'h8899AABB, 0, 32'h0, 2, 0, 1);
    chk("wr_addr_10", last_wa, 32'h10);
    do_req(0, 0, 2'b00, 0, 32'h13, 32'h0, 0, 32'hFFFFFF88, 2, 1, 0);
    do_req(0, 0, 2'b00, 1, 32'h13, 32'h0, 0, 32'h00000088, 2, 1, 0);
    do_req(0, 1, 2'b01, 0, 32'h12, 32'h1234, 0, 32'h0, 3, 1, 1);
    chk("rmw_half_data", last_wd, 32'h1234AABB);
    chk("rmw_half_addr", last_wa, 32'h10);
    do_req(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1234AABB, 2, 1, 0);
    do_req(1, 0, 2'b01, 0, 32'h10, 32'h0, 0, 32'hFFFFAABB, 2, 1, 0);
    do_req(0, 0, 2'b01, 1, 32'h12, 32'h0, 0, 32'h00001234, 2, 1, 0);
    do_req(1, 1, 2'b00, 0, 32'h11, 32'hFFFFFF5A, 0, 32'h0, 3, 1, 1);
    chk("rmw_byte_data", last_wd, 32'h12345ABB);
    do_req(0, 0, 2'b00, 0, 32'h11, 32'h0, 0, 32'h0000005A, 2, 1, 0);

    do_req(0, 0, 2'b10, 0, 32'h06, 32'h0, 1, 32'h0, 1, 0, 0);
    do_req(0, 1, 2'b01, 0, 32'h11, 32'h1, 1, 32'h0, 1, 0, 0);
    do_req(1, 0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0, 1, 0, 0);

    do_req(1, 1, 2'b10, 0, 32'h7C, 32'hDEADBEEF, 0, 32'h0, 2, 0, 1);
    chk("wr_addr_7c", last_wa, 32'h7C);
    do_req(0, 0, 2'b10, 0, 32'h7C, 32'h0, 0, 32'hDEADBEEF, 2, 1, 0);

    do_req(0, 1, 2'b10, 0, 32'h14, 32'h11111111, 0, 32'h0, 2, 0, 1);
    do_req(1, 1, 2'b10, 0, 32'h18, 32'h22222222, 0, 32'h0, 2, 0, 1);
    rr(4, 32'h14, 32'h11111111, 32'h18, 32'h22222222);

    do_req(1, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, 32'h0, 2, 0, 1);
    @(negedge clk);
    req_we[0] = 1'b1;
    req_size[1:0] = 2'b10;
    req_addr[31:0] = 32'h20;
    req_wdata[31:0] = 32'h0BADBEEF;
    req_valid[0] = 1'b1;
    #1;
    chk("abort_accept", {30'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("abort_wr_active", {31'b0, mem_write}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_wr_drop", {31'b0, mem_write}, 32'd0);
    chk("abort_rsp", {30'b0, rsp_valid}, 32'd0);
    model_lg = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    rr(2, 32'h20, 32'hCAFEF00D, 32'h7C, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
